// File: rtl/div_seq_32.sv
// ============================================================================
//  Module      : div_seq_32
//  Description : Multicycle signed 32-bit restoring divider, one quotient bit
//                per clock. Optional remainder output under DIV_REMAINDER_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_seq_32 #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
`ifdef DIV_REMAINDER_EN
    output logic [WIDTH-1:0] data_remainder,
`endif
    output logic             busy
);

    localparam int                 c_CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(ITER - 1);
    localparam logic [WIDTH-1:0]   c_MIN   = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH:0]     r_rem;
    logic [WIDTH-1:0]   r_dvd;
    logic [WIDTH-1:0]   r_dvs;
    logic               r_sign;
`ifdef DIV_REMAINDER_EN
    logic               r_sign_a;
`endif

    logic               w_b_zero;
    logic               w_ovf;
    logic               w_exc;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH+1:0]   w_shift;
    logic [WIDTH+1:0]   w_trial;
    logic               w_qbit;

    assign w_b_zero = (data_operandB == '0);
    assign w_ovf    = (data_operandA == c_MIN) && (data_operandB == '1);
    assign w_exc    = w_b_zero || w_ovf;
    assign w_abs_a  = data_operandA[WIDTH-1] ? (~data_operandA + 1'b1) : data_operandA;
    assign w_abs_b  = data_operandB[WIDTH-1] ? (~data_operandB + 1'b1) : data_operandB;

    // Shifted remainder always stays below 2*divisor, so the top bit of the
    // trial difference is a reliable "went negative" indicator.
    assign w_shift  = {r_rem, r_dvd[WIDTH-1]};
    assign w_trial  = w_shift - {2'b00, r_dvs};
    assign w_qbit   = ~w_trial[WIDTH+1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_rem          <= '0;
            r_dvd          <= '0;
            r_dvs          <= '0;
            r_sign         <= 1'b0;
`ifdef DIV_REMAINDER_EN
            r_sign_a       <= 1'b0;
            data_remainder <= '0;
`endif
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;

            case (r_state)
                S_RUN: begin
                    r_rem <= w_qbit ? w_trial[WIDTH:0] : w_shift[WIDTH:0];
                    r_dvd <= {r_dvd[WIDTH-2:0], w_qbit};
                    if (r_cnt == c_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_FIX;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                S_FIX: begin
                    // A start arriving here aborts, so no result is committed.
                    if (!ctrl_DIV) begin
                        data_result    <= r_sign ? (~r_dvd + 1'b1) : r_dvd;
`ifdef DIV_REMAINDER_EN
                        data_remainder <= r_sign_a ? (~r_rem[WIDTH-1:0] + 1'b1)
                                                   : r_rem[WIDTH-1:0];
`endif
                        data_exception <= 1'b0;
                        data_resultRDY <= 1'b1;
                        busy           <= 1'b0;
                        r_state        <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Ready still low here means an exception result is pending.
                    if (!data_resultRDY) begin
                        data_result    <= r_dvd;
`ifdef DIV_REMAINDER_EN
                        data_remainder <= '0;
`endif
                        data_exception <= 1'b1;
                        data_resultRDY <= 1'b1;
                    end
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            // A start in any state wins over the state update above.
            if (ctrl_DIV) begin
                r_cnt    <= '0;
                r_rem    <= '0;
                r_dvs    <= w_abs_b;
                r_sign   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
`ifdef DIV_REMAINDER_EN
                r_sign_a <= data_operandA[WIDTH-1];
`endif
                busy     <= 1'b1;
                if (w_exc) begin
                    r_dvd   <= w_ovf ? c_MIN : '0;
                    r_state <= S_DONE;
                end else begin
                    r_dvd   <= w_abs_a;
                    r_state <= S_RUN;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_div_seq_32.sv
// ============================================================================
//  Module      : tb_div_seq_32
//  Description : Directed self-checking bench for div_seq_32.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_seq_32;

    logic        clock;
    logic        reset;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
`ifdef DIV_REMAINDER_EN
    logic [31:0] data_remainder;
`endif
    logic        busy;

    int checks   = 0;
    int failures = 0;

    div_seq_32 #(.WIDTH(32), .ITER(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
`ifdef DIV_REMAINDER_EN
        .data_remainder (data_remainder),
`endif
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Start edge falls between the two negedges; returns one negedge after it.
    task automatic do_start(input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_DIV      = 1'b1;
        @(negedge clock);
        ctrl_DIV      = 1'b0;
        data_operandA = 32'hDEADBEEF;
        data_operandB = 32'h0;
    endtask

    // Cycles after the start edge until ready is seen; -1 on timeout.
    task automatic wait_rdy(input int maxc, output int lat);
        lat = 0;
        while (data_resultRDY !== 1'b1 && lat < maxc) begin
            @(negedge clock);
            lat++;
        end
        if (data_resultRDY !== 1'b1) lat = -1;
    endtask

    task automatic test_reset;
        checks++; if (data_result !== 32'h0) begin failures++; $display("FAIL reset_result: got %h expected %h", data_result, 32'h0); end
        checks++; if (data_exception !== 1'b0) begin failures++; $display("FAIL reset_exc: got %b expected 0", data_exception); end
        checks++; if (data_resultRDY !== 1'b0) begin failures++; $display("FAIL reset_rdy: got %b expected 0", data_resultRDY); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    endtask

    task automatic test_positive;
        int lat;
        do_start(32'd100, 32'd7);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL pos_busy: got %b expected 1", busy); end
        wait_rdy(60, lat);
        checks++; if (lat != 33) begin failures++; $display("FAIL pos_latency: got %0d expected 33", lat); end
        checks++; if (data_result !== 32'd14) begin failures++; $display("FAIL pos_result: got %h expected %h", data_result, 32'd14); end
        checks++; if (data_exception !== 1'b0) begin failures++; $display("FAIL pos_exc: got %b expected 0", data_exception); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL pos_busy_done: got %b expected 0", busy); end
`ifdef DIV_REMAINDER_EN
        checks++; if (data_remainder !== 32'd2) begin failures++; $display("FAIL pos_rem: got %h expected %h", data_remainder, 32'd2); end
`endif
        @(negedge clock);
        checks++; if (data_resultRDY !== 1'b0) begin failures++; $display("FAIL pos_pulse_width: got %b expected 0", data_resultRDY); end
        checks++; if (data_result !== 32'd14) begin failures++; $display("FAIL pos_hold: got %h expected %h", data_result, 32'd14); end
    endtask

    task automatic test_negative;
        int lat;
        do_start(32'hFFFFFF9C, 32'd7);
        wait_rdy(60, lat);
        checks++; if (lat != 33) begin failures++; $display("FAIL neg_latency: got %0d expected 33", lat); end
        checks++; if (data_result !== 32'hFFFFFFF2) begin failures++; $display("FAIL neg_result: got %h expected %h", data_result, 32'hFFFFFFF2); end
        checks++; if (data_exception !== 1'b0) begin failures++; $display("FAIL neg_exc: got %b expected 0", data_exception); end
`ifdef DIV_REMAINDER_EN
        checks++; if (data_remainder !== 32'hFFFFFFFE) begin failures++; $display("FAIL neg_rem: got %h expected %h", data_remainder, 32'hFFFFFFFE); end
`endif
    endtask

    task automatic test_div_zero;
        int lat;
        do_start(32'd5, 32'd0);
        wait_rdy(60, lat);
        checks++; if (lat != 1) begin failures++; $display("FAIL dz_latency: got %0d expected 1", lat); end
        checks++; if (data_result !== 32'h0) begin failures++; $display("FAIL dz_result: got %h expected %h", data_result, 32'h0); end
        checks++; if (data_exception !== 1'b1) begin failures++; $display("FAIL dz_exc: got %b expected 1", data_exception); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL dz_busy: got %b expected 0", busy); end
`ifdef DIV_REMAINDER_EN
        checks++; if (data_remainder !== 32'h0) begin failures++; $display("FAIL dz_rem: got %h expected %h", data_remainder, 32'h0); end
`endif
        @(negedge clock);
        checks++; if (data_resultRDY !== 1'b0) begin failures++; $display("FAIL dz_pulse_width: got %b expected 0", data_resultRDY); end
        checks++; if (data_exception !== 1'b1) begin failures++; $display("FAIL dz_exc_hold: got %b expected 1", data_exception); end
    endtask

    task automatic test_overflow;
        int lat;
        do_start(32'h80000000, 32'hFFFFFFFF);
        wait_rdy(60, lat);
        checks++; if (lat != 1) begin failures++; $display("FAIL ovf_latency: got %0d expected 1", lat); end
        checks++; if (data_result !== 32'h80000000) begin failures++; $display("FAIL ovf_result: got %h expected %h", data_result, 32'h80000000); end
        checks++; if (data_exception !== 1'b1) begin failures++; $display("FAIL ovf_exc: got %b expected 1", data_exception); end
    endtask

    task automatic test_min_by_two;
        int lat;
        do_start(32'h80000000, 32'd2);
        wait_rdy(60, lat);
        checks++; if (lat != 33) begin failures++; $display("FAIL min2_latency: got %0d expected 33", lat); end
        checks++; if (data_result !== 32'hC0000000) begin failures++; $display("FAIL min2_result: got %h expected %h", data_result, 32'hC0000000); end
        checks++; if (data_exception !== 1'b0) begin failures++; $display("FAIL min2_exc: got %b expected 0", data_exception); end
`ifdef DIV_REMAINDER_EN
        checks++; if (data_remainder !== 32'h0) begin failures++; $display("FAIL min2_rem: got %h expected %h", data_remainder, 32'h0); end
`endif
    endtask

    task automatic test_abort;
        int lat;
        int pulses;
        pulses = 0;
        do_start(32'd1000, 32'd10);
        repeat (9) begin
            @(negedge clock);
            if (data_resultRDY === 1'b1) pulses++;
        end
        do_start(32'd9, 32'd3);
        wait_rdy(60, lat);
        checks++; if (lat != 33) begin failures++; $display("FAIL abort_latency: got %0d expected 33", lat); end
        checks++; if (data_result !== 32'd3) begin failures++; $display("FAIL abort_result: got %h expected %h", data_result, 32'd3); end
        repeat (40) begin
            @(negedge clock);
            if (data_resultRDY === 1'b1) pulses++;
        end
        checks++; if (pulses != 0) begin failures++; $display("FAIL abort_extra_pulses: got %0d expected 0", pulses); end
    endtask

    task automatic test_reset_midop;
        int lat;
        int pulses;
        pulses = 0;
        do_start(32'd1000, 32'd10);
        repeat (19) @(negedge clock);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rst_busy_before: got %b expected 1", busy); end
        #2 reset = 1'b1;
        #1;
        checks++; if (data_result !== 32'h0) begin failures++; $display("FAIL rst_result: got %h expected %h", data_result, 32'h0); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b expected 0", busy); end
        checks++; if (data_resultRDY !== 1'b0) begin failures++; $display("FAIL rst_rdy: got %b expected 0", data_resultRDY); end
        @(negedge clock);
        reset = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (data_resultRDY === 1'b1) pulses++;
        end
        checks++; if (pulses != 0) begin failures++; $display("FAIL rst_pulses: got %0d expected 0", pulses); end
        do_start(32'd1000, 32'd10);
        wait_rdy(60, lat);
        checks++; if (lat != 33) begin failures++; $display("FAIL rst_fresh_latency: got %0d expected 33", lat); end
        checks++; if (data_result !== 32'd100) begin failures++; $display("FAIL rst_fresh_result: got %h expected %h", data_result, 32'd100); end
    endtask

    task automatic test_back_to_back;
        int lat;
        // Normal result, new start issued in its ready cycle.
        do_start(32'd100, 32'd7);
        wait_rdy(60, lat);
        checks++; if (data_result !== 32'd14) begin failures++; $display("FAIL b2b_first_result: got %h expected %h", data_result, 32'd14); end
        data_operandA = 32'd9;
        data_operandB = 32'd3;
        ctrl_DIV      = 1'b1;
        @(negedge clock);
        ctrl_DIV      = 1'b0;
        wait_rdy(60, lat);
        checks++; if (lat != 33) begin failures++; $display("FAIL b2b_second_latency: got %0d expected 33", lat); end
        checks++; if (data_result !== 32'd3) begin failures++; $display("FAIL b2b_second_result: got %h expected %h", data_result, 32'd3); end

        // Exception pending; new start in the DONE cycle keeps its pulse.
        do_start(32'd5, 32'd0);
        data_operandA = 32'd100;
        data_operandB = 32'd7;
        ctrl_DIV      = 1'b1;
        @(negedge clock);
        ctrl_DIV      = 1'b0;
        checks++; if (data_resultRDY !== 1'b1) begin failures++; $display("FAIL b2b_exc_rdy: got %b expected 1", data_resultRDY); end
        checks++; if (data_exception !== 1'b1) begin failures++; $display("FAIL b2b_exc_flag: got %b expected 1", data_exception); end
        checks++; if (data_result !== 32'h0) begin failures++; $display("FAIL b2b_exc_result: got %h expected %h", data_result, 32'h0); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_exc_busy: got %b expected 1", busy); end
        @(negedge clock);
        wait_rdy(60, lat);
        if (lat >= 0) lat = lat + 1;
        checks++; if (lat != 33) begin failures++; $display("FAIL b2b_after_exc_latency: got %0d expected 33", lat); end
        checks++; if (data_result !== 32'd14) begin failures++; $display("FAIL b2b_after_exc_result: got %h expected %h", data_result, 32'd14); end
        checks++; if (data_exception !== 1'b0) begin failures++; $display("FAIL b2b_after_exc_flag: got %b expected 0", data_exception); end
    endtask

    initial begin
        reset         = 1'b1;
        ctrl_DIV      = 1'b0;
        data_operandA = 32'h0;
        data_operandB = 32'h0;
        repeat (2) @(negedge clock);
        test_reset;
        reset = 1'b0;
        test_positive;
        test_negative;
        test_div_zero;
        test_overflow;
        test_min_by_two;
        test_abort;
        test_reset_midop;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
